dap_resp_sender: RTL and testbench

Response-packet transmitter for the DAP controller. Command workers write their response bytes into the shared response RAM and report `packet_len`. This block reads those bytes back and streams them to the USB endpoint as an AXI-stream packet, optionally preceded by the command ID byte. It is the read side of the response RAM and the final stage of every command.

---
 rtl/dap_resp_sender.sv | 172 +++++++++++++++++
 tb/tb_dap_resp_sender.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dap_resp_sender.sv
// Streams a response packet out of the response RAM as an AXI-stream packet.
// Define DAP_RESP_PREFIX_EN to prepend the command ID byte to every packet.
module dap_resp_sender #(
  parameter int MAX_LEN = 512
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       start,
  input  logic [7:0] cmd_id,
  input  logic [9:0] packet_len,
  output logic [9:0] ram_read_addr,
  output logic       ram_read_en,
  input  logic [7:0] ram_read_data,
  output logic       dap_out_tvalid,
  input  logic       dap_out_tready,
  output logic [7:0] dap_out_tdata,
  output logic       dap_out_tlast,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_dbg
);

  // Handshake: a beat transfers on a clock edge where tvalid and tready are
  // both high; once tvalid rises, tvalid/tdata/tlast hold until that edge.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [9:0] MAX_LEN_C = 10'(MAX_LEN);

  state_t     state, state_nxt;
  logic [9:0] len_q, rd_cnt, tx_cnt, len_clamped;
  logic       rd_pend;
  logic [1:0] buf_cnt;
  logic [7:0] buf0, buf1;
  logic       in_flight, rd_issue, pay_valid, pay_last, pop, buf_pop, buf_push;
  logic [7:0] pay_data;

`ifdef DAP_RESP_PREFIX_EN
  logic [7:0] cmd_q;
`else
  logic unused_cmd;
  assign unused_cmd = ^cmd_id;
`endif

  assign len_clamped = (packet_len > MAX_LEN_C) ? MAX_LEN_C : packet_len;
  assign in_flight   = (state == PREFIX) || (state == STREAM);

  // A read may only be issued if the byte it returns is guaranteed a slot:
  // bytes held plus the byte arriving this cycle must leave room for one more.
  assign rd_issue  = in_flight && (rd_cnt < len_q) &&
                     ((buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && !rd_pend));
  assign pay_valid = (state == STREAM) && ((buf_cnt != 2'd0) || rd_pend);
  assign pay_data  = (buf_cnt != 2'd0) ? buf0 : ram_read_data;
  assign pay_last  = (tx_cnt == len_q - 10'd1);
  assign pop       = pay_valid && dap_out_tready;
  assign buf_pop   = pop && (buf_cnt != 2'd0);
  assign buf_push  = rd_pend && !(pop && (buf_cnt == 2'd0));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    dap_out_tvalid = 1'b0;
    dap_out_tdata  = 8'd0;
    dap_out_tlast  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DAP_RESP_PREFIX_EN
          state_nxt = PREFIX;
`else
          state_nxt = (len_clamped == 10'd0) ? DONE : STREAM;
`endif
        end
      end
`ifdef DAP_RESP_PREFIX_EN
      PREFIX: begin
        dap_out_tvalid = 1'b1;
        dap_out_tdata  = cmd_q;
        dap_out_tlast  = (len_q == 10'd0);
        if (dap_out_tready) state_nxt = (len_q == 10'd0) ? DONE : STREAM;
      end
`endif
      STREAM: begin
        dap_out_tvalid = pay_valid;
        dap_out_tdata  = pay_valid ? pay_data : 8'd0;
        dap_out_tlast  = pay_valid && pay_last;
        if (pop && pay_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign ram_read_en   = rd_issue;
  assign ram_read_addr = rd_cnt;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
`ifdef DAP_RESP_PREFIX_EN
      cmd_q   <= 8'd0;
`endif
      len_q   <= 10'd0;
      rd_cnt  <= 10'd0;
      tx_cnt  <= 10'd0;
      rd_pend <= 1'b0;
      buf_cnt <= 2'd0;
      buf0    <= 8'd0;
      buf1    <= 8'd0;
    end else if (!enable) begin
`ifdef DAP_RESP_PREFIX_EN
      cmd_q   <= 8'd0;
`endif
      len_q   <= 10'd0;
      rd_cnt  <= 10'd0;
      tx_cnt  <= 10'd0;
      rd_pend <= 1'b0;
      buf_cnt <= 2'd0;
      buf0    <= 8'd0;
      buf1    <= 8'd0;
    end else if ((state == IDLE) && start) begin
`ifdef DAP_RESP_PREFIX_EN
      cmd_q   <= cmd_id;
`endif
      len_q   <= len_clamped;
      rd_cnt  <= 10'd0;
      tx_cnt  <= 10'd0;
      rd_pend <= 1'b0;
      buf_cnt <= 2'd0;
    end else begin
      rd_pend <= rd_issue;
      if (rd_issue) rd_cnt <= rd_cnt + 10'd1;
      if (pop)      tx_cnt <= tx_cnt + 10'd1;
      // Two-entry buffer: buf0 is the head; the arriving RAM byte bypasses
      // straight to the stream when the buffer is empty.
      case ({buf_pop, buf_push})
        2'b01: begin
          if (buf_cnt == 2'd0) buf0 <= ram_read_data;
          else                 buf1 <= ram_read_data;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b10: begin
          buf0    <= buf1;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf0 <= ram_read_data;
          end else begin
            buf0 <= buf1;
            buf1 <= ram_read_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dap_resp_sender.sv
// Self-checking bench for dap_resp_sender: randomized packets against a
// queue-based packet model, with a decoupled stream monitor.
module tb_dap_resp_sender;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cmd_id = 8'd0;
  logic [9:0] packet_len = 10'd0;
  logic [9:0] ram_read_addr;
  logic       ram_read_en;
  logic [7:0] ram_read_data = 8'd0;
  logic       dap_out_tvalid;
  logic       dap_out_tready = 1'b0;
  logic [7:0] dap_out_tdata;
  logic       dap_out_tlast;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

`ifdef DAP_RESP_PREFIX_EN
  localparam bit PREFIX_ON = 1'b1;
`else
  localparam bit PREFIX_ON = 1'b0;
`endif
  localparam int MAX_LEN = 512;

  dap_resp_sender #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .start(start),
    .cmd_id(cmd_id), .packet_len(packet_len),
    .ram_read_addr(ram_read_addr), .ram_read_en(ram_read_en),
    .ram_read_data(ram_read_data),
    .dap_out_tvalid(dap_out_tvalid), .dap_out_tready(dap_out_tready),
    .dap_out_tdata(dap_out_tdata), .dap_out_tlast(dap_out_tlast),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // response RAM model: registered read, one cycle latency
  logic [7:0] mem [0:1023];
  always @(posedge clk) if (ram_read_en) ram_read_data <= mem[ram_read_addr];

  // scoreboard state
  logic [8:0] exp_q[$];
  int chk_cnt = 0;
  int pass_cnt = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  bit ready_all = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tvalid"}, 32'(dap_out_tvalid), 32'd0);
    check({tag, "_tdata"},  32'(dap_out_tdata),  32'd0);
    check({tag, "_tlast"},  32'(dap_out_tlast),  32'd0);
    check({tag, "_rd_en"},  32'(ram_read_en),    32'd0);
    check({tag, "_rd_addr"}, 32'(ram_read_addr), 32'd0);
    check({tag, "_busy"},   32'(busy),           32'd0);
    check({tag, "_done"},   32'(done),           32'd0);
  endtask

  // ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      dap_out_tready = ready_all ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // monitor: compares every accepted beat and checks hold-while-stalled
  initial begin
    bit stall;
    logic [8:0] held;
    stall = 1'b0;
    held = 9'd0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_tvalid", 32'(dap_out_tvalid), 32'd1);
          check("hold_beat", 32'({dap_out_tlast, dap_out_tdata}), 32'(held));
        end
        if (done) done_cnt++;
        if (dap_out_tvalid && dap_out_tready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL beat_unexpected: got last=%0b data=0x%02h, no beat expected",
                     dap_out_tlast, dap_out_tdata);
          end else begin
            check("beat", 32'({dap_out_tlast, dap_out_tdata}), 32'(exp_q.pop_front()));
          end
        end
        stall = dap_out_tvalid && !dap_out_tready;
        held = {dap_out_tlast, dap_out_tdata};
      end
    end
  end

  // reference model: the packet is [cmd_id] then RAM[0 .. min(len,MAX)-1]
  task automatic push_expected(input logic [7:0] id, input int plen);
    int n;
    n = (plen > MAX_LEN) ? MAX_LEN : plen;
    if (PREFIX_ON) exp_q.push_back({1'(n == 0), id});
    for (int i = 0; i < n; i++) exp_q.push_back({1'(i == n - 1), mem[i]});
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
  endtask

  task automatic issue_start(input logic [7:0] id, input int plen);
    @(posedge clk);
    #1;
    start = 1'b1;
    cmd_id = id;
    packet_len = plen[9:0];
    @(posedge clk);
    #1;
    start = 1'b0;
    cmd_id = 8'($urandom);
    packet_len = 10'($urandom);
  endtask

  // driver: one full packet; done cycle checked only with tready held high
  task automatic send(input logic [7:0] id, input int plen, input bit chk_time);
    int n, c;
    bit seen;
    n = (plen > MAX_LEN) ? MAX_LEN : plen;
    push_expected(id, plen);
    issue_start(id, plen);
    c = 1;
    seen = 1'b0;
    while (c < 5000) begin
      @(negedge clk);
      if (c == 1) check("busy_cycle1", 32'(busy), 32'd1);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      c++;
      start = (c == 2) && (n >= 2);
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    if (chk_time) check("done_cycle", 32'(c), (!PREFIX_ON && n == 0) ? 32'd1 : 32'(n + 2));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    check("busy_fall", 32'(busy), 32'd0);
    check("done_single", 32'(done), 32'd0);
  endtask

  task automatic abort_test();
    int g, d0, target;
    fill_mem();
    ready_all = 1'b1;
    push_expected(8'hA5, 10);
    target = hs_cnt + (PREFIX_ON ? 4 : 3);
    d0 = done_cnt;
    issue_start(8'hA5, 10);
    g = 0;
    while (hs_cnt < target && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("abort_reached_beats", 32'(hs_cnt >= target), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle("abort");
    exp_q.delete();
    @(posedge clk);
    #1;
    enable = 1'b1;
    repeat (4) @(posedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(d0));
  endtask

  task automatic reset_test();
    fill_mem();
    ready_all = 1'b1;
    push_expected(8'h3C, 20);
    issue_start(8'h3C, 20);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_idle("async_reset");
    exp_q.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    enable = 1'b1;

    fill_mem();
    mem[0] = 8'h00;
    send(8'h09, 1, 1'b1);

    fill_mem();
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    send(8'h5A, 4, 1'b1);

    send(8'hC3, 0, 1'b1);

    fill_mem();
    ready_all = 1'b0;
    send(8'($urandom), 64, 1'b0);
    ready_all = 1'b1;

    fill_mem();
    send(8'($urandom), 1000, 1'b1);

    for (int k = 0; k < 8; k++) begin
      fill_mem();
      ready_all = 1'($urandom_range(0, 1));
      send(8'($urandom), $urandom_range(0, 80), ready_all);
    end
    ready_all = 1'b1;

    abort_test();
    fill_mem();
    send(8'h77, 10, 1'b1);

    reset_test();
    fill_mem();
    ready_all = 1'b0;
    send(8'h12, 33, 1'b0);
    ready_all = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
